// File: rtl/scanner_link_arbiter.sv
// scanner_link_arbiter: round-robin sharing of one MSB-first serial link between two scanners,
// sending one byte per fixed 8-clock slot and padding unused slots with an idle byte.
module scanner_link_arbiter #(
    parameter logic [7:0] IDLE_BYTE = 8'h00,
    parameter logic [7:0] CMD_BIN   = 8'd7,
    parameter logic [7:0] CMD_ASCII = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] cmd0,
    input  logic [7:0] data0,
    input  logic [7:0] cmd1,
    input  logic [7:0] data1,
    input  logic       link_ready,
    output logic       ser_out,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_cmd;
    logic [7:0] r_data;
    logic       r_ptr;
    logic [1:0] r_grant;
    logic [1:0] r_done;
    logic       r_busy;
    logic       w_edge;
    logic       w_has_data;
    logic       w_pkt_end;
    logic [1:0] w_req;
    logic       w_go;
    logic       w_win;
    assign w_edge     = r_bit_cnt == 3'd7;
    assign w_has_data = (r_cmd == CMD_BIN) || (r_cmd == CMD_ASCII);
    assign w_pkt_end  = (r_state == S_DATA) || (r_state == S_CMD && !w_has_data);
    // The finishing owner's request is still held until its done pulse, so it is consumed here.
    assign w_req      = req & ~(w_pkt_end ? r_grant : 2'b00);
    assign w_go       = (|w_req) && link_ready;
    assign w_win      = (&w_req) ? r_ptr : w_req[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_cmd     <= 8'h00;
            r_data    <= 8'h00;
            r_ptr     <= 1'b0;
            r_grant   <= 2'b00;
            r_done    <= 2'b00;
            r_busy    <= 1'b0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_done    <= 2'b00;
            if (!w_edge) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end else begin
                if (w_pkt_end)
                    r_done <= r_grant;
                if (r_state == S_CMD && w_has_data) begin
                    r_state <= S_DATA;
                    r_shift <= r_data;
                end else if (w_go) begin
                    r_state <= S_CMD;
                    r_grant <= w_win ? 2'b10 : 2'b01;
                    r_busy  <= 1'b1;
                    r_ptr   <= ~w_win;
                    r_cmd   <= w_win ? cmd1 : cmd0;
                    r_data  <= w_win ? data1 : data0;
                    r_shift <= w_win ? cmd1 : cmd0;
                end else begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_shift <= IDLE_BYTE;
                end
            end
        end
    end
    assign ser_out = r_shift[7];
    assign grant   = r_grant;
    assign done    = r_done;
    assign busy    = r_busy;
endmodule
